// File: rtl/endec_pkg.sv
// ----------------------------------------------------------------------------
// endec_pkg
// Shared constants, codeword bit positions and helpers for the Hamming(7,4)
// receive path.
//   CW_W / DATA_W / SYND_W : codeword, data and syndrome widths
//   P1..D4                 : zero-based vector index of codeword positions 1..7
//   dec_res_t              : one decoded result as held in the output buffer
//   hamming74_syndrome()   : raw syndrome {s4,s2,s1} of a codeword
// ----------------------------------------------------------------------------
package endec_pkg;

   localparam int unsigned CW_W   = 7;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned SYND_W = 3;

   // Position k of the codeword lives at vector index k-1.
   localparam int unsigned P1 = 0;
   localparam int unsigned P2 = 1;
   localparam int unsigned D1 = 2;
   localparam int unsigned P4 = 3;
   localparam int unsigned D2 = 4;
   localparam int unsigned D3 = 5;
   localparam int unsigned D4 = 6;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SYND_W-1:0] synd;
      logic              corr;
   } dec_res_t;

   function automatic logic [SYND_W-1:0] hamming74_syndrome(input logic [CW_W-1:0] cw);
      logic s1, s2, s4;
      s1 = cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4];
      s2 = cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4];
      s4 = cw[P4] ^ cw[D2] ^ cw[D3] ^ cw[D4];
      return {s4, s2, s1};
   endfunction

endpackage

// File: rtl/hamming74_dec.sv
// ----------------------------------------------------------------------------
// hamming74_dec
// Combinational Hamming(7,4) single-error-correcting decoder.
//   i_cw        : codeword, index k-1 holds position k
//   o_data      : corrected data {c7,c6,c5,c3}
//   o_syndrome  : raw syndrome {s4,s2,s1}
//   o_corrected : syndrome non-zero, bit at position o_syndrome was flipped
// ----------------------------------------------------------------------------
module hamming74_dec
   import endec_pkg::*;
(
   input  logic [CW_W-1:0]   i_cw,
   output logic [DATA_W-1:0] o_data,
   output logic [SYND_W-1:0] o_syndrome,
   output logic              o_corrected
);

   logic [SYND_W-1:0] w_syn;
   logic [CW_W-1:0]   w_mask;
   logic [CW_W-1:0]   w_fixed;

   assign w_syn = hamming74_syndrome(i_cw);

   // The syndrome value is the 1-based position of the erroneous bit.
   assign w_mask  = (w_syn == '0) ? '0 : (CW_W'(1) << (w_syn - 3'd1));
   assign w_fixed = i_cw ^ w_mask;

   assign o_data      = {w_fixed[D4], w_fixed[D3], w_fixed[D2], w_fixed[D1]};
   assign o_syndrome  = w_syn;
   assign o_corrected = (w_syn != '0);

endmodule

// File: rtl/hamming_frame_rx.sv
// ----------------------------------------------------------------------------
// hamming_frame_rx
// Serial Hamming(7,4) receiver: collects 7 qualified bits (c1 first), decodes
// one edge later and presents the nibble in a one-entry valid/ready buffer.
//   clk, rst_n     : clock, asynchronous active-low reset
//   ena            : block enable, all state holds when low
//   bit_in/valid   : serial data and its qualifier
//   clr            : synchronous soft clear (qualified by ena)
//   out_ready      : consumer handshake
//   out_valid/data/syndrome/corrected : buffered decode result
//   overflow       : sticky, a result was dropped on a full buffer
//   frame_cnt      : decoded codewords, saturating
//   corr_cnt       : codewords with non-zero syndrome, saturating
// ----------------------------------------------------------------------------
module hamming_frame_rx
   import endec_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              clr,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [SYND_W-1:0] out_syndrome,
   output logic              out_corrected,
   output logic              overflow,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  corr_cnt
);

   logic [2:0]        r_bit_cnt;
   logic [CW_W-1:0]   r_shift;
   logic [CW_W-1:0]   r_cw;
   logic              r_pending;
   logic              r_valid;
   dec_res_t          r_buf;
   logic              r_ovf;
   logic [CNT_W-1:0]  r_frame_cnt;
   logic [CNT_W-1:0]  r_corr_cnt;

   logic              w_clr;
   logic              w_accept;
   logic              w_last;
   logic              w_decode;
   logic              w_load;
   logic              w_drop;
   logic              w_drain;
   logic [CW_W-1:0]   w_shift_nxt;
   logic [DATA_W-1:0] w_dec_data;
   logic [SYND_W-1:0] w_dec_syn;
   logic              w_dec_corr;

   hamming74_dec u_dec (
      .i_cw        (r_cw),
      .o_data      (w_dec_data),
      .o_syndrome  (w_dec_syn),
      .o_corrected (w_dec_corr)
   );

   assign w_clr       = ena & clr;
   assign w_accept    = ena & bit_valid & ~clr;
   assign w_last      = w_accept & (r_bit_cnt == 3'(CW_W - 1));
   assign w_decode    = ena & r_pending & ~clr;
   // A decode lands in the buffer when it is empty or being drained this edge.
   assign w_load      = w_decode & (~r_valid | out_ready);
   assign w_drop      = w_decode & r_valid & ~out_ready;
   assign w_drain     = ena & ~clr & r_valid & out_ready & ~w_load;
   // Shift right so that the first accepted bit (c1) ends at index 0.
   assign w_shift_nxt = {bit_in, r_shift[CW_W-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_cw      <= '0;
         r_pending <= 1'b0;
      end else if (w_clr) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_pending <= 1'b0;
      end else begin
         if (w_accept) begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 3'd1;
         end
         if (w_last) begin
            r_cw      <= w_shift_nxt;
            r_pending <= 1'b1;
         end else if (w_decode) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_buf       <= '0;
         r_ovf       <= 1'b0;
         r_frame_cnt <= '0;
         r_corr_cnt  <= '0;
      end else if (w_clr) begin
         r_valid     <= 1'b0;
         r_ovf       <= 1'b0;
         r_frame_cnt <= '0;
         r_corr_cnt  <= '0;
      end else begin
         if (w_load) begin
            r_valid <= 1'b1;
            r_buf   <= '{data: w_dec_data, synd: w_dec_syn, corr: w_dec_corr};
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_decode && (r_frame_cnt != '1)) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
         if (w_decode && w_dec_corr && (r_corr_cnt != '1)) begin
            r_corr_cnt <= r_corr_cnt + CNT_W'(1);
         end
      end
   end

   assign out_valid     = r_valid;
   assign out_data      = r_buf.data;
   assign out_syndrome  = r_buf.synd;
   assign out_corrected = r_buf.corr;
   assign overflow      = r_ovf;
   assign frame_cnt     = r_frame_cnt;
   assign corr_cnt      = r_corr_cnt;

endmodule
